downsizer_module: RTL and testbench

DOWNSIZER_MODULE -- requirements
Module: downsizer_module

---
 rtl/interconnect_pkg.sv | 15 +
 rtl/downsizer_module_lane_priority_enc.sv | 31 +++
 rtl/downsizer_module.sv | 108 ++++++++++
 tb/tb_downsizer_module.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/interconnect_pkg.sv
// Shared types and defaults for the width converters (downsizer and upsizer).
//   state_t          : converter FSM state (EMPTY = no beat held, DRAIN = beat held)
//   DEF_T_DATA_WIDTH : default narrow lane width in bits
//   DEF_T_DATA_RATIO : default number of narrow lanes per wide beat
package interconnect_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam int DEF_T_DATA_WIDTH = 4;
  localparam int DEF_T_DATA_RATIO = 2;

endpackage

// File: rtl/downsizer_module_lane_priority_enc.sv
// lane_priority_enc: picks the lowest set bit of a pending-lane mask.
// Purely combinational.
//   pend_i  : pending-lane mask
//   low_o   : one-hot copy of the lowest set bit (all zero if none set)
//   idx_o   : index of the lowest set bit (0 if none set)
//   final_o : the lowest set bit is the only set bit
module lane_priority_enc #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     pend_i,
  output logic [N-1:0]     low_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             final_o
);

  always_comb begin
    low_o = '0;
    idx_o = '0;
    // Walk from the top down so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_i[i]) begin
        low_o    = '0;
        low_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
      end
    end
    final_o = (|pend_i) && ((pend_i & ~low_o) == '0);
  end

endmodule

// File: rtl/downsizer_module.sv
// downsizer_module: splits one wide beat of T_DATA_RATIO lanes into a stream
// of narrow lanes, lane 0 first, one lane per cycle when m_ready_i is high.
//   clk, rst                         : clock, async active-high reset
//   s_data_i/s_keep_i/s_last_i       : wide beat, per-lane keep mask, packet end
//   s_valid_i/s_ready_o              : wide-side handshake
//   m_data_o/m_last_o                : narrow lane, packet end
//   m_valid_o/m_ready_i              : narrow-side handshake
// Build option: DOWNSIZER_KEEP_EN honours s_keep_i (lanes with keep=0 are
// skipped, keep==0 beats are consumed silently). Without it every lane is sent.
//
// state | meaning
// EMPTY | no beat held, ready to accept
// DRAIN | beat held, at least one lane pending
module downsizer_module
  import interconnect_pkg::*;
#(
  parameter int T_DATA_WIDTH = DEF_T_DATA_WIDTH,
  parameter int T_DATA_RATIO = DEF_T_DATA_RATIO
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO-1:0],
  input  logic [T_DATA_RATIO-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  localparam int IDX_W = (T_DATA_RATIO > 1) ? $clog2(T_DATA_RATIO) : 1;

  state_t                  state_q, state_d;
  logic [T_DATA_WIDTH-1:0] data_q [T_DATA_RATIO-1:0];
  logic [T_DATA_WIDTH-1:0] data_d [T_DATA_RATIO-1:0];
  logic [T_DATA_RATIO-1:0] pend_q, pend_d;
  logic                    last_q, last_d;

  logic [T_DATA_RATIO-1:0] keep_eff;
  logic [T_DATA_RATIO-1:0] low_bit;
  logic [IDX_W-1:0]        lane_idx;
  logic                    is_final;
  logic                    xfer;
  logic                    accept;

`ifdef DOWNSIZER_KEEP_EN
  assign keep_eff = s_keep_i;
`else
  logic unused_keep;
  assign unused_keep = ^s_keep_i;
  assign keep_eff    = '1;
`endif

  lane_priority_enc #(
    .N     (T_DATA_RATIO),
    .IDX_W (IDX_W)
  ) u_enc (
    .pend_i  (pend_q),
    .low_o   (low_bit),
    .idx_o   (lane_idx),
    .final_o (is_final)
  );

  assign m_valid_o = (state_q == DRAIN);
  assign m_data_o  = m_valid_o ? data_q[lane_idx] : '0;
  // Pending lanes drain low to high, so the final pending lane is the highest kept one.
  assign m_last_o  = m_valid_o & last_q & is_final;
  // Refill is allowed while the last pending lane leaves, giving back-to-back beats.
  assign s_ready_o = ~rst & ((state_q == EMPTY) | (is_final & m_ready_i));

  assign xfer   = m_valid_o & m_ready_i;
  assign accept = s_valid_i & s_ready_o;

  always_comb begin
    data_d = data_q;
    pend_d = pend_q;
    last_d = last_q;
    if (xfer) begin
      pend_d = pend_q & ~low_bit;
    end
    if (accept) begin
      data_d = s_data_i;
      pend_d = keep_eff;
      // An all-empty beat is swallowed together with its packet end.
      last_d = s_last_i & (|keep_eff);
    end
    state_d = (|pend_d) ? DRAIN : EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      pend_q  <= '0;
      last_q  <= 1'b0;
      for (int i = 0; i < T_DATA_RATIO; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_downsizer_module.sv
module tb_downsizer_module;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] s_data [1:0];
  logic [1:0] s_keep = 2'b00;
  logic       s_last = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [3:0] m_data;
  logic       m_last;
  logic       m_valid;
  logic       m_ready = 1'b0;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  downsizer_module #(
    .T_DATA_WIDTH (4),
    .T_DATA_RATIO (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data_i  (s_data),
    .s_keep_i  (s_keep),
    .s_last_i  (s_last),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .m_data_o  (m_data),
    .m_last_o  (m_last),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready)
  );

  typedef struct {
    logic       sv;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [1:0] keep;
    logic       last;
    logic       mr;
    logic       ev;
    logic [3:0] ed;
    logic       el;
    logic       es;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(logic sv, logic [3:0] d0, logic [3:0] d1, logic [1:0] keep,
                              logic last, logic mr, logic ev, logic [3:0] ed, logic el, logic es);
    vec_t v;
    v.sv = sv; v.d0 = d0; v.d1 = d1; v.keep = keep; v.last = last; v.mr = mr;
    v.ev = ev; v.ed = ed; v.el = el; v.es = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge: drive inputs, check outputs, advance to next falling edge.
  task automatic step(input string name, input logic sv, input logic [3:0] d0, input logic [3:0] d1,
                      input logic [1:0] keep, input logic last, input logic mr,
                      input logic ev, input logic [3:0] ed, input logic el, input logic es);
    s_valid   = sv;
    s_data[0] = d0;
    s_data[1] = d1;
    s_keep    = keep;
    s_last    = last;
    m_ready   = mr;
    #1;
    chk({name, ".m_valid"}, {7'd0, m_valid}, {7'd0, ev});
    chk({name, ".m_data"},  {4'd0, m_data},  {4'd0, ed});
    chk({name, ".m_last"},  {7'd0, m_last},  {7'd0, el});
    chk({name, ".s_ready"}, {7'd0, s_ready}, {7'd0, es});
    @(negedge clk);
  endtask

  task automatic idle(input string name, input logic es);
    step(name, 1'b0, 4'h0, 4'h0, 2'b11, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, es);
  endtask

  initial begin
    s_data[0] = 4'h0;
    s_data[1] = 4'h0;

    // single beat, ready always high
    tbl[0]  = mk(1, 4'h3, 4'hA, 2'b11, 1, 1,  0, 4'h0, 0, 1);
    tbl[1]  = mk(0, 4'h0, 4'h0, 2'b11, 0, 1,  1, 4'h3, 0, 0);
    tbl[2]  = mk(0, 4'h0, 4'h0, 2'b11, 0, 1,  1, 4'hA, 1, 1);
    tbl[3]  = mk(0, 4'h0, 4'h0, 2'b11, 0, 1,  0, 4'h0, 0, 1);
    // continuous stream B0..B3
    tbl[4]  = mk(1, 4'h1, 4'h2, 2'b11, 0, 1,  0, 4'h0, 0, 1);
    tbl[5]  = mk(1, 4'h3, 4'h4, 2'b11, 1, 1,  1, 4'h1, 0, 0);
    tbl[6]  = mk(1, 4'h3, 4'h4, 2'b11, 1, 1,  1, 4'h2, 0, 1);
    tbl[7]  = mk(1, 4'h5, 4'h6, 2'b11, 0, 1,  1, 4'h3, 0, 0);
    tbl[8]  = mk(1, 4'h5, 4'h6, 2'b11, 0, 1,  1, 4'h4, 1, 1);
    tbl[9]  = mk(1, 4'h7, 4'h8, 2'b11, 1, 1,  1, 4'h5, 0, 0);
    tbl[10] = mk(1, 4'h7, 4'h8, 2'b11, 1, 1,  1, 4'h6, 0, 1);
    tbl[11] = mk(0, 4'h0, 4'h0, 2'b11, 0, 1,  1, 4'h7, 0, 0);
    tbl[12] = mk(0, 4'h0, 4'h0, 2'b11, 0, 1,  1, 4'h8, 1, 1);
    tbl[13] = mk(0, 4'h0, 4'h0, 2'b11, 0, 1,  0, 4'h0, 0, 1);
    // back-pressure on lane 0 then on the final lane
    tbl[14] = mk(1, 4'h3, 4'hA, 2'b11, 1, 0,  0, 4'h0, 0, 1);
    tbl[15] = mk(0, 4'h0, 4'h0, 2'b11, 0, 0,  1, 4'h3, 0, 0);
    tbl[16] = mk(0, 4'h0, 4'h0, 2'b11, 0, 0,  1, 4'h3, 0, 0);
    tbl[17] = mk(0, 4'h0, 4'h0, 2'b11, 0, 0,  1, 4'h3, 0, 0);
    tbl[18] = mk(0, 4'h0, 4'h0, 2'b11, 0, 1,  1, 4'h3, 0, 0);
    tbl[19] = mk(0, 4'h0, 4'h0, 2'b11, 0, 0,  1, 4'hA, 1, 0);
    tbl[20] = mk(0, 4'h0, 4'h0, 2'b11, 0, 1,  1, 4'hA, 1, 1);
    tbl[21] = mk(0, 4'h0, 4'h0, 2'b11, 0, 1,  0, 4'h0, 0, 1);

    // reset state, with a beat offered to make sure it is refused
    s_valid = 1'b1;
    s_keep  = 2'b11;
    s_data[0] = 4'hF;
    s_data[1] = 4'hE;
    m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst.m_valid", {7'd0, m_valid}, 8'd0);
    chk("rst.m_last",  {7'd0, m_last},  8'd0);
    chk("rst.m_data",  {4'd0, m_data},  8'd0);
    chk("rst.s_ready", {7'd0, s_ready}, 8'd0);
    s_valid = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      step($sformatf("vec%0d", i), tbl[i].sv, tbl[i].d0, tbl[i].d1, tbl[i].keep, tbl[i].last,
           tbl[i].mr, tbl[i].ev, tbl[i].ed, tbl[i].el, tbl[i].es);
    end

    // reset after lane 0 has transferred: lane 1 must never appear
    step("mid.acc",  1, 4'h3, 4'hA, 2'b11, 1, 1, 0, 4'h0, 0, 1);
    step("mid.lane0", 0, 4'h0, 4'h0, 2'b11, 0, 1, 1, 4'h3, 0, 0);
    rst = 1'b1;
    #1;
    chk("mid.rst_valid", {7'd0, m_valid}, 8'd0);
    chk("mid.rst_ready", {7'd0, s_ready}, 8'd0);
    chk("mid.rst_data",  {4'd0, m_data},  8'd0);
    @(negedge clk);
    rst = 1'b0;
    idle("mid.rel0", 1);
    idle("mid.rel1", 1);
    idle("mid.rel2", 1);

    // partial keep: only lane 1 kept
    step("k10.acc", 1, 4'h5, 4'h9, 2'b10, 1, 1, 0, 4'h0, 0, 1);
`ifdef DOWNSIZER_KEEP_EN
    step("k10.l1", 0, 4'h0, 4'h0, 2'b11, 0, 1, 1, 4'h9, 1, 1);
`else
    step("k10.l0", 0, 4'h0, 4'h0, 2'b11, 0, 1, 1, 4'h5, 0, 0);
    step("k10.l1", 0, 4'h0, 4'h0, 2'b11, 0, 1, 1, 4'h9, 1, 1);
`endif
    idle("k10.end", 1);

    // empty keep beat
    step("k00.acc", 1, 4'h5, 4'h9, 2'b00, 1, 1, 0, 4'h0, 0, 1);
`ifdef DOWNSIZER_KEEP_EN
    idle("k00.none0", 1);
    idle("k00.none1", 1);
`else
    step("k00.l0", 0, 4'h0, 4'h0, 2'b11, 0, 1, 1, 4'h5, 0, 0);
    step("k00.l1", 0, 4'h0, 4'h0, 2'b11, 0, 1, 1, 4'h9, 1, 1);
    idle("k00.end", 1);
`endif

    // beat with lane 0 only, loaded in the same cycle a final lane leaves
    step("b2b.acc0", 1, 4'hC, 4'hD, 2'b11, 0, 1, 0, 4'h0, 0, 1);
    step("b2b.l0",   1, 4'h6, 4'h7, 2'b01, 1, 1, 1, 4'hC, 0, 0);
    step("b2b.l1",   1, 4'h6, 4'h7, 2'b01, 1, 1, 1, 4'hD, 0, 1);
`ifdef DOWNSIZER_KEEP_EN
    step("b2b.n0",   0, 4'h0, 4'h0, 2'b11, 0, 1, 1, 4'h6, 1, 1);
`else
    step("b2b.n0",   0, 4'h0, 4'h0, 2'b11, 0, 1, 1, 4'h6, 0, 0);
    step("b2b.n1",   0, 4'h0, 4'h0, 2'b11, 0, 1, 1, 4'h7, 1, 1);
`endif
    idle("b2b.end", 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
